shift_add_mult_4bit: RTL and testbench
======================================

# shift_add_mult_4bit

Sequential 4×4 unsigned multiplier that sits directly downstream of the 4-bit ripple-carry adder. It instantiates one `adder_4bit` and drives it once per cycle with the partial-product accumulator and multiplicand. It consumes the adder's `sum` and `carry_out` to build an 8-bit product over four add/shift iterations. A start/busy/done handshake connects it to the issuing control logic.

## Interface
- Parameters: none. Operand width is fixed at 4 bits by the adder stage.
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- start  input  1  request; sampled only in IDLE
- a  input  4  multiplicand, unsigned; captured on accepted start
- b  input  4  multiplier, unsigned; captured on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; product valid
- product  output  8  unsigned a×b; held until the next accepted start completes

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - M[3:0], the multiplicand.
  - Q[3:0], the multiplier, which becomes the product low nibble.
  - A[3:0], the accumulator, which becomes the product high nibble.
  - C, the adder carry.
  - cnt[1:0], the iteration counter.
- IDLE, start=1: load M←a, Q←b, A←0, C←0, cnt←0, go to RUN. If start=0, remain in IDLE.
- RUN, each cycle: the adder instance computes in1=A, in2=M, carry_in=0.
  - If Q[0]=1: {C', A'} = {carry_out, sum}.
  - If Q[0]=0: {C', A'} = {0, A}.
  - Register {C, A, Q} ← {0, C', A', Q[3:1]}, a logical right shift of the 9-bit {C', A', Q}.
  - cnt ← cnt+1. When cnt==3, go to DONE.
- DONE: done=1. On entry, the product register is loaded with {A, Q}. Next cycle go to IDLE unconditionally.
- start is ignored in RUN and DONE. Changes on a/b are ignored outside the accepting IDLE cycle.
- Arithmetic: unsigned only. The maximum result is 15×15 = 225, which fits in 8 bits with no overflow. The adder carry is never dropped: it shifts into A[3].
- Outputs are registered: busy and done decode the registered state, and product comes from a dedicated register. No combinational path runs from inputs to outputs.

## Timing
- Reset (asynchronous assert, any state):
  - state=IDLE, busy=0, done=0, product=8'h00.
  - M, Q, A, C and cnt clear to 0.
- Reset mid-RUN or mid-DONE aborts the operation. No done pulse is produced, and product reads 0.
- Deassertion is synchronous to clk externally; the first start is accepted on the first rising edge after release.
- Edge E0 (start=1 in IDLE): accept. busy=1 from E0.
- Edges E1–E4: four RUN iterations.
- Edge E4: state becomes DONE. product is updated at E4 and done=1 during the cycle after E4.
- Edge E5: state IDLE, busy=0, done=0. Latency from the accepting edge to done is 4 cycles; done lasts exactly 1 cycle.
- start held high continuously: accepts at E0, E6, E12, … The throughput period is 6 cycles.
- product changes only at the E4-equivalent edge of each operation. It is stable at all other times, including during the next operation's RUN.
- The adder path is single-cycle combinational; it needs no multicycle constraint.

## Test plan
- Reset, then a=4'hF, b=4'hF, start pulse: busy high 5 cycles; done pulse 4 cycles after accept; product=8'hE1. Then IDLE with busy=0.
- a=4'hA, b=4'h3 → product=8'h1E. a=4'h0, b=4'hD → 8'h00. a=4'h7, b=4'h0 → 8'h00. a=4'h1, b=4'h8 → 8'h08.
- Exhaustive sweep of all 256 a/b pairs with one start per operation: every product equals a×b, and every done is exactly 1 cycle wide.
- start asserted with a=4'h3, b=4'h5, then start=1 with a=4'hF, b=4'hF during RUN and during DONE: the second request is ignored; product=8'h0F; a single done pulse.
- start held high for 20 cycles with a=4'h9, b=4'h6: accepts occur 6 cycles apart; each done shows product=8'h36; busy is low exactly one cycle between operations.
- rst_n pulsed low after E2 of a 4'hF×4'hF run: busy, done and product clear immediately. No done pulse follows. A new start after release gives a correct result.

Source files
------------

// File: rtl/shift_add_mult_4bit.sv
// shift_add_mult_4bit: sequential 4x4 unsigned shift-add multiplier built around one 4-bit adder

// adder_4bit: 4-bit adder with carry in and carry out
module adder_4bit (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);
    assign {carry_out, sum} = 5'(in1) + 5'(in2) + 5'(carry_in);
endmodule

module shift_add_mult_4bit (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] product_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e     state_q, state_d;
    logic [3:0] m_q, m_d, q_q, q_d, a_q, a_d;
    logic       c_q, c_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;
    logic [3:0] sum;
    logic       cout, c_n;
    logic [3:0] a_n;
    // C is always 0 when the adder is used (cleared on load, 0 shifted in), so it serves as the zero carry-in
    adder_4bit u_add (
        .in1      (a_q),
        .in2      (m_q),
        .carry_in (c_q),
        .sum      (sum),
        .carry_out(cout)
    );
    assign c_n = q_q[0] ? cout : 1'b0;
    assign a_n = q_q[0] ? sum : a_q;
    // next-state: load on accepted start, add/shift four times, publish product on entering DONE
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        a_d       = a_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                m_d     = a_i;
                q_d     = b_i;
                a_d     = 4'h0;
                c_d     = 1'b0;
                cnt_d   = 2'd0;
            end
            RUN: begin
                c_d   = 1'b0;
                a_d   = {c_n, a_n[3:1]};
                q_d   = {a_n[0], q_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d   = DONE;
                    product_d = {a_d, q_d};
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers, asynchronously cleared
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            m_q       <= 4'h0;
            q_q       <= 4'h0;
            a_q       <= 4'h0;
            c_q       <= 1'b0;
            cnt_q     <= 2'd0;
            product_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            a_q       <= a_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == DONE;
    assign product_o = product_q;
endmodule

// File: tb/tb_shift_add_mult_4bit.sv
// tb_shift_add_mult_4bit: directed and table-driven checks of the shift-add multiplier
module tb_shift_add_mult_4bit;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] a_i = 4'h0;
    logic [3:0] b_i = 4'h0;
    logic       busy_o, done_o;
    logic [7:0] product_o;
    int checks = 0;
    int failures = 0;

    shift_add_mult_4bit dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .product_o(product_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // caller is at a negedge; issues one start pulse and follows the operation to IDLE
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string nm);
        int lat;
        int bc;
        logic [7:0] prev;
        prev = product_o;
        start_i = 1'b1; a_i = a; b_i = b;
        @(negedge clk_i);
        start_i = 1'b0; a_i = ~a; b_i = ~b;
        lat = 0; bc = 0;
        while (!done_o && lat < 12) begin
            if (busy_o) bc++;
            if (lat == 2) chk({nm, "_prod_stable"}, product_o, prev);
            @(negedge clk_i);
            lat++;
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_busy_before_done"}, bc, 4);
        chk({nm, "_busy_at_done"}, busy_o, 1);
        chk({nm, "_product"}, product_o, exp);
        @(negedge clk_i);
        chk({nm, "_done_width"}, done_o, 0);
        chk({nm, "_idle"}, busy_o, 0);
        chk({nm, "_prod_held"}, product_o, exp);
    endtask

    initial begin
        vec_t vt[7];
        int ndone;
        vt[0] = '{4'hF, 4'hF, 8'hE1};
        vt[1] = '{4'hA, 4'h3, 8'h1E};
        vt[2] = '{4'h0, 4'hD, 8'h00};
        vt[3] = '{4'h7, 4'h0, 8'h00};
        vt[4] = '{4'h1, 4'h8, 8'h08};
        vt[5] = '{4'hC, 4'hB, 8'h84};
        vt[6] = '{4'h5, 4'h9, 8'h2D};

        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_product", product_o, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vt[i]) do_op(vt[i].a, vt[i].b, vt[i].p, $sformatf("vec%0d", i));

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                do_op(4'(x), 4'(y), 8'(x * y), $sformatf("sweep_%0d_%0d", x, y));

        // second request during RUN and DONE must be ignored
        start_i = 1'b1; a_i = 4'h3; b_i = 4'h5;
        ndone = 0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk_i);
            if (done_o) ndone++;
            start_i = (k < 5); a_i = 4'hF; b_i = 4'hF;
        end
        chk("ignore_done_count", ndone, 1);
        chk("ignore_product", product_o, 8'h0F);
        chk("ignore_idle", busy_o, 0);

        // start held high: accepts every 6 cycles
        start_i = 1'b1; a_i = 4'h9; b_i = 4'h6;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            chk($sformatf("held_done_k%0d", k), done_o, (k % 6) == 4);
            chk($sformatf("held_busy_k%0d", k), busy_o, (k % 6) != 5);
            if (done_o) chk($sformatf("held_prod_k%0d", k), product_o, 8'h36);
        end
        start_i = 1'b0;
        repeat (8) @(negedge clk_i);
        chk("held_drain_idle", busy_o, 0);
        chk("held_drain_prod", product_o, 8'h36);

        // asynchronous reset mid-RUN aborts the operation
        start_i = 1'b1; a_i = 4'hF; b_i = 4'hF;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_product", product_o, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (done_o || busy_o) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        chk("arst_product_hold", product_o, 8'h00);
        do_op(4'hF, 4'hF, 8'hE1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
